sram_pattern_sequencer: RTL and testbench
=========================================

# sram_pattern_sequencer

Parametrised test-pattern source for the SRAM test harness. It steps through a selectable list of data patterns: fixed, walking-bit, address-derived, pseudo-random and custom. For each write or read address it supplies the expected word, so the read-back checker regenerates exactly the sequence the writer used. It sits between the test controller (which drives the `next`, `rewind` and `step` strobes) and the SRAM write-data and compare paths.

## Interface
Parameters:
- `DATA_BITS`, 16: pattern width; even, 2..32.
- `ADDR_BITS`, 20: width of `addr`.
- `PATTERN_MASK`, 11'h7FF: bit n enables state n (states 0..10); disabled states are skipped.
- `LFSR_SEED`, 32'h0000_0001: LFSR reload value; a value of 0 is replaced by 1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `next`  in  1  one-cycle strobe: advance to the next pattern or walk position.
- `rewind`  in  1  one-cycle strobe: reload the LFSR to `LFSR_SEED` (start of each sweep).
- `step`  in  1  one-cycle strobe: advance the LFSR by one (once per address).
- `addr`  in  ADDR_BITS  current address, used by the address patterns.
- `custom`  in  DATA_BITS  word used in the CUSTOM state.
- `pattern`  out  DATA_BITS  combinational word for the current state, index, `addr` and LFSR.
- `state`  out  4  current state, registered.
- `sub_index`  out  $clog2(DATA_BITS)  walk position, registered.
- `last`  out  1  high when the next `next` enters DONE.
- `done`  out  1  registered; high in DONE.

## Operation
States and the pattern each produces:
- 0 ZEROS: 0.
- 1 ONES: all 1.
- 2 ALT_10: {DATA_BITS/2{2'b10}}.
- 3 ALT_01: {DATA_BITS/2{2'b01}}.
- 4 HALF_ONES: low DATA_BITS/2 bits set.
- 5 WALK_ONES: 1 << sub_index.
- 6 WALK_ZEROS: ~(1 << sub_index).
- 7 ADDR: addr zero-extended, or truncated to its low DATA_BITS bits.
- 8 ADDR_INV: bitwise NOT of the ADDR value.
- 9 LFSR: lfsr[DATA_BITS-1:0].
- 10 CUSTOM: `custom`.
- 11 DONE: 0. Terminal state; `next` is ignored.

State transitions:
- `next` in a walk state with sub_index < DATA_BITS-1: sub_index increments and the state holds.
- Otherwise `next` moves to the lowest enabled state above the current one, or to DONE if none exists.
- Entering any state clears sub_index to 0 and reloads the LFSR.

LFSR:
- 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
- Step: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 0).
- `step` is honoured only in state LFSR; it is ignored in every other state.
- `rewind` reloads the LFSR in any state.

Priority when strobes coincide:
- `next` beats `rewind`, and `rewind` beats `step`.
- Because a transition also reloads the LFSR, `next` with `step` leaves the LFSR at the seed.

`last` is combinational from state and sub_index. It is high when the current state is the highest enabled state and, for a walk state, sub_index = DATA_BITS-1.

Reset values:
- state = lowest enabled state, or DONE if PATTERN_MASK = 0.
- sub_index = 0, lfsr = seed.
- done = 1 only when PATTERN_MASK = 0; otherwise 0.

Reset mid-sequence returns to these values immediately, with no dependence on `clk`.

## Timing
- All strobes are sampled on the rising edge of `clk`.
- State, sub_index, lfsr and done update at that edge.
- `pattern` is valid in the same cycle as the state and `addr` it is derived from: zero latency from `addr`, and one edge after a strobe.
- `done` rises at the edge that enters DONE and stays high until reset.
- Strobes may be asserted back-to-back every cycle.

## Test plan
- DATA_BITS=16, default mask. Reset, then one `next` per cycle. Required sequence:
  - `pattern` reads 0000, FFFF, AAAA, 5555, 00FF.
  - WALK_ONES: 0001..8000 (16 steps). WALK_ZEROS: FFFE..7FFF.
  - With addr=0x12345: ADDR = 2345, ADDR_INV = DCBA.
  - Then LFSR, then CUSTOM = `custom`.
  - One more `next`: done=1 and state=11. A further `next` leaves the state unchanged.
- LFSR state, seed 1. Three `step` strobes give pattern 0001 -> 0003 -> 0002 -> 0001. `rewind` then returns 0001; `rewind` together with `step` gives 0001.
- PATTERN_MASK = 11'b100_0000_0011. Reset gives ZEROS. Then `next` -> ONES -> CUSTOM (with `last` = 1) -> DONE.
- PATTERN_MASK = 0. Reset gives state=11 and done=1.
- Mid-WALK_ONES at sub_index=7, assert `reset` between clock edges. Outputs return immediately: state=0, sub_index=0, done=0, pattern=0000.
- `step` strobes in ZEROS followed by `next` into the LFSR path leave the LFSR at the seed.

Source files
------------

// File: rtl/sram_pattern_sequencer.sv
// SRAM test-pattern source: fixed, walking, address, LFSR and custom words.
// Writer and read-back checker share one sequence per address.
module sram_pattern_sequencer #(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned ADDR_BITS    = 20,
  parameter logic [10:0] PATTERN_MASK = 11'h7FF,
  parameter logic [31:0] LFSR_SEED    = 32'h0000_0001
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         next,
  input  logic                         rewind,
  input  logic                         step,
  input  logic [ADDR_BITS-1:0]         addr,
  input  logic [DATA_BITS-1:0]         custom,
  output logic [DATA_BITS-1:0]         pattern,
  output logic [3:0]                   state,
  output logic [$clog2(DATA_BITS)-1:0] sub_index,
  output logic                         last,
  output logic                         done
);

  localparam int unsigned SW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] SUB_MAX = SW'(DATA_BITS - 1);
  localparam logic [31:0] SEED =
    (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

  typedef enum logic [3:0] {
    S_ZEROS, S_ONES, S_ALT10, S_ALT01,
    S_HALF, S_WALK1, S_WALK0, S_ADDR,
    S_ADDRN, S_LFSR, S_CUSTOM, S_DONE
  } state_e;

  function automatic state_e first_en(input logic [10:0] m);
    state_e s;
    s = S_DONE;
    for (int i = 10; i >= 0; i--)
      if (m[i]) s = state_e'(4'(i));
    return s;
  endfunction

  localparam state_e RST_STATE = first_en(PATTERN_MASK);

  state_e          state_q, state_d, nxt_up;
  logic [SW-1:0]   sub_q, sub_d;
  logic [31:0]     lfsr_q, lfsr_d, lfsr_step;
  logic            done_q, done_d;
  logic            walk, at_end;
  logic [DATA_BITS-1:0] addr_w, one_hot;

  // Address word: low DATA_BITS bits of addr, zero-extended when narrower.
  if (ADDR_BITS >= DATA_BITS) begin : g_trunc
    assign addr_w = addr[DATA_BITS-1:0];
    if (ADDR_BITS > DATA_BITS) begin : g_spare
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_BITS-1:DATA_BITS];
    end
  end else begin : g_ext
    assign addr_w = {{(DATA_BITS-ADDR_BITS){1'b0}}, addr};
  end

  // Lowest enabled state above the current one, else DONE.
  always_comb begin
    nxt_up = S_DONE;
    for (int i = 10; i >= 0; i--)
      if (PATTERN_MASK[i] && (4'(i) > state_q))
        nxt_up = state_e'(4'(i));
  end

  assign walk      = (state_q == S_WALK1) || (state_q == S_WALK0);
  assign at_end    = (sub_q == SUB_MAX);
  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^
                     (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
  assign last      = (state_q != S_DONE) && (nxt_up == S_DONE) &&
                     (!walk || at_end);

  // Next state: next > rewind > step; any transition reloads the LFSR.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    lfsr_d  = lfsr_q;
    done_d  = done_q;
    if (next && state_q != S_DONE) begin
      if (walk && !at_end) begin
        sub_d = sub_q + 1'b1;
      end else begin
        state_d = nxt_up;
        sub_d   = '0;
        lfsr_d  = SEED;
        done_d  = (nxt_up == S_DONE);
      end
    end else if (rewind) begin
      lfsr_d = SEED;
    end else if (step && state_q == S_LFSR) begin
      lfsr_d = lfsr_step;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
      sub_q   <= '0;
      lfsr_q  <= SEED;
      done_q  <= (RST_STATE == S_DONE);
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      lfsr_q  <= lfsr_d;
      done_q  <= done_d;
    end
  end

  assign one_hot = {{(DATA_BITS-1){1'b0}}, 1'b1} << sub_q;

  // Pattern word for the current state, index, addr and LFSR.
  always_comb begin
    pattern = '0;
    case (state_q)
      S_ONES:   pattern = '1;
      S_ALT10:  pattern = {(DATA_BITS/2){2'b10}};
      S_ALT01:  pattern = {(DATA_BITS/2){2'b01}};
      S_HALF:   pattern = {{(DATA_BITS/2){1'b0}},
                           {(DATA_BITS/2){1'b1}}};
      S_WALK1:  pattern = one_hot;
      S_WALK0:  pattern = ~one_hot;
      S_ADDR:   pattern = addr_w;
      S_ADDRN:  pattern = ~addr_w;
      S_LFSR:   pattern = lfsr_q[DATA_BITS-1:0];
      S_CUSTOM: pattern = custom;
      default:  pattern = '0;
    endcase
  end

  assign state     = state_q;
  assign sub_index = sub_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sram_pattern_sequencer.sv
// Directed bench for sram_pattern_sequencer with three mask settings.
// Expected words are hand-computed constants.
module tb_sram_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        next = 1'b0, rewind = 1'b0, step = 1'b0;
  logic [19:0] addr = 20'h12345;
  logic [15:0] custom = 16'hC0DE;

  logic [15:0] p0, p1, p2;
  logic [3:0]  s0, s1, s2, x0, x1, x2;
  logic        l0, l1, l2, d0, d1, d2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_pattern_sequencer #(.DATA_BITS(16), .ADDR_BITS(20)) u0 (
    .clk(clk), .reset(reset), .next(next), .rewind(rewind),
    .step(step), .addr(addr), .custom(custom), .pattern(p0),
    .state(s0), .sub_index(x0), .last(l0), .done(d0));

  sram_pattern_sequencer #(.DATA_BITS(16), .ADDR_BITS(20),
    .PATTERN_MASK(11'b100_0000_0011)) u1 (
    .clk(clk), .reset(reset), .next(next), .rewind(rewind),
    .step(step), .addr(addr), .custom(custom), .pattern(p1),
    .state(s1), .sub_index(x1), .last(l1), .done(d1));

  sram_pattern_sequencer #(.DATA_BITS(16), .ADDR_BITS(20),
    .PATTERN_MASK(11'h000)) u2 (
    .clk(clk), .reset(reset), .next(next), .rewind(rewind),
    .step(step), .addr(addr), .custom(custom), .pattern(p2),
    .state(s2), .sub_index(x2), .last(l2), .done(d2));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobes driven on the falling edge, sampled #1 after the rising edge.
  task automatic tick(input logic n, input logic r, input logic s);
    @(negedge clk);
    next = n; rewind = r; step = s;
    @(posedge clk);
    #1;
    next = 1'b0; rewind = 1'b0; step = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(s0), 32'd0);
    chk("rst_pat", 32'(p0), 32'h0000);
    chk("rst_done", 32'(d0), 32'd0);
    chk("rst_sub", 32'(x0), 32'd0);
    chk("m403_rst_state", 32'(s1), 32'd0);
    chk("m0_state", 32'(s2), 32'd11);
    chk("m0_done", 32'(d2), 32'd1);
    chk("m0_pat", 32'(p2), 32'h0000);

    tick(1, 0, 0);
    chk("ones", 32'(p0), 32'hFFFF);
    chk("m403_ones", 32'(s1), 32'd1);
    chk("m403_ones_last", 32'(l1), 32'd0);
    tick(1, 0, 0);
    chk("alt10", 32'(p0), 32'hAAAA);
    chk("m403_custom", 32'(s1), 32'd10);
    chk("m403_custom_pat", 32'(p1), 32'hC0DE);
    chk("m403_last", 32'(l1), 32'd1);
    tick(1, 0, 0);
    chk("alt01", 32'(p0), 32'h5555);
    chk("m403_done_st", 32'(s1), 32'd11);
    chk("m403_done", 32'(d1), 32'd1);
    tick(1, 0, 0);
    chk("half", 32'(p0), 32'h00FF);
    tick(1, 0, 0);
    chk("walk1_0", 32'(p0), 32'h0001);
    chk("walk1_state", 32'(s0), 32'd5);
    for (int i = 1; i < 16; i++) begin
      tick(1, 0, 0);
      chk($sformatf("walk1_%0d", i), 32'(p0), 32'h1 << i);
    end
    chk("walk1_last", 32'(l0), 32'd0);
    tick(1, 0, 0);
    chk("walk0_0", 32'(p0), 32'hFFFE);
    chk("walk0_state", 32'(s0), 32'd6);
    for (int i = 1; i < 16; i++) begin
      tick(1, 0, 0);
      chk($sformatf("walk0_%0d", i), 32'(p0),
          32'hFFFF & ~(32'h1 << i));
    end
    tick(1, 0, 0);
    chk("addr", 32'(p0), 32'h2345);
    addr = 20'hABCDE;
    #1;
    chk("addr_comb", 32'(p0), 32'hBCDE);
    addr = 20'h12345;
    tick(1, 0, 0);
    chk("addr_inv", 32'(p0), 32'hDCBA);
    tick(1, 0, 0);
    chk("lfsr_state", 32'(s0), 32'd9);
    chk("lfsr_seed", 32'(p0), 32'h0001);
    tick(0, 0, 1);
    chk("lfsr_s1", 32'(p0), 32'h0003);
    tick(0, 0, 1);
    chk("lfsr_s2", 32'(p0), 32'h0002);
    tick(0, 0, 1);
    chk("lfsr_s3", 32'(p0), 32'h0001);
    tick(0, 0, 1);
    chk("lfsr_s4", 32'(p0), 32'h0003);
    tick(0, 1, 0);
    chk("rewind", 32'(p0), 32'h0001);
    tick(0, 0, 1);
    chk("lfsr_s5", 32'(p0), 32'h0003);
    tick(0, 1, 1);
    chk("rewind_step", 32'(p0), 32'h0001);
    tick(1, 0, 0);
    chk("custom", 32'(p0), 32'hC0DE);
    chk("custom_last", 32'(l0), 32'd1);
    tick(1, 0, 0);
    chk("done_state", 32'(s0), 32'd11);
    chk("done", 32'(d0), 32'd1);
    chk("done_pat", 32'(p0), 32'h0000);
    tick(1, 0, 0);
    chk("done_hold", 32'(s0), 32'd11);
    chk("done_hold_d", 32'(d0), 32'd1);

    // Async reset mid-walk.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5 + 7; i++) tick(1, 0, 0);
    chk("mid_sub", 32'(x0), 32'd7);
    chk("mid_pat", 32'(p0), 32'h0080);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", 32'(s0), 32'd0);
    chk("arst_sub", 32'(x0), 32'd0);
    chk("arst_done", 32'(d0), 32'd0);
    chk("arst_pat", 32'(p0), 32'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Step outside LFSR is ignored; next+step into LFSR leaves the seed.
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("zeros_step", 32'(p0), 32'h0000);
    for (int i = 0; i < 38; i++) tick(1, 0, 0);
    chk("pre_lfsr", 32'(s0), 32'd8);
    tick(1, 0, 1);
    chk("ns_state", 32'(s0), 32'd9);
    chk("ns_seed", 32'(p0), 32'h0001);
    tick(0, 0, 1);
    chk("ns_step", 32'(p0), 32'h0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
